// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types, including the EX/MEM pipeline record.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // Fields captured by the EX/MEM latch; an all-zero value is a bubble.
    typedef struct packed {
        logic     valid;
        logic     zero;
        logic     neg;
        logic     regwen;
        logic     dren;
        logic     dwen;
        word_t    alu_out;
        word_t    store_dat;
        word_t    pc;
        regbits_t wsel;
    } exmem_t;

    localparam exmem_t ExmemBubble = '0;

endpackage

// File: rtl/exmem_latch.sv
// EX/MEM pipeline register with flush/stall control, a signed-overflow trap
// capture (first trap wins until acknowledged) and a sticky halt flag.
module exmem_latch
    import cpu_types_pkg::*;
#(
    parameter bit TRAP_EN = 1'b1
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ex_valid,
    input  word_t    alu_out,
    input  logic     alu_zero,
    input  logic     alu_neg,
    input  logic     alu_ovf,
    input  logic     ovf_chk,
    input  word_t    store_dat,
    input  regbits_t wsel,
    input  logic     regwen,
    input  logic     dren,
    input  logic     dwen,
    input  logic     halt,
    input  word_t    ex_pc,
    input  logic     stall,
    input  logic     flush,
    input  logic     exc_ack,
    output logic     mem_valid,
    output logic     mem_zero,
    output logic     mem_neg,
    output logic     mem_regwen,
    output logic     mem_dren,
    output logic     mem_dwen,
    output logic     mem_halt,
    output word_t    mem_alu_out,
    output word_t    mem_store_dat,
    output word_t    mem_pc,
    output regbits_t mem_wsel,
    output logic     exc_pending,
    output word_t    exc_pc
);

    exmem_t exmem_d, exmem_q;
    logic   halt_d, halt_q;
    logic   pend_d, pend_q;
    word_t  epc_d, epc_q;
    logic   load;
    logic   trap;

    always_comb begin
        exmem_d = exmem_q;
        halt_d  = halt_q;
        pend_d  = pend_q;
        epc_d   = epc_q;

        load = !flush && !stall;
        trap = TRAP_EN && load && ex_valid && ovf_chk && alu_ovf;

        if (flush) begin
            exmem_d = ExmemBubble;
        end else if (!stall) begin
            exmem_d.valid     = ex_valid;
            exmem_d.zero      = alu_zero;
            exmem_d.neg       = alu_neg;
            exmem_d.regwen    = ex_valid && regwen && (wsel != '0) && !trap;
            exmem_d.dren      = ex_valid && dren && !trap;
            exmem_d.dwen      = ex_valid && dwen && !trap;
            exmem_d.alu_out   = alu_out;
            exmem_d.store_dat = store_dat;
            exmem_d.pc        = ex_pc;
            exmem_d.wsel      = wsel;
        end

        if (load && ex_valid && halt) begin
            halt_d = 1'b1;
        end

        // A new trap overrides the recorded PC only when nothing is pending or
        // the pending one is being acknowledged on this same edge.
        if (trap) begin
            pend_d = 1'b1;
            if (!pend_q || exc_ack) begin
                epc_d = ex_pc;
            end
        end else if (exc_ack) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exmem_q <= ExmemBubble;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt_q <= 1'b0;
            pend_q <= 1'b0;
            epc_q  <= '0;
        end else begin
            halt_q <= halt_d;
            pend_q <= pend_d;
            epc_q  <= epc_d;
        end
    end

    assign mem_valid     = exmem_q.valid;
    assign mem_zero      = exmem_q.zero;
    assign mem_neg       = exmem_q.neg;
    assign mem_regwen    = exmem_q.regwen;
    assign mem_dren      = exmem_q.dren;
    assign mem_dwen      = exmem_q.dwen;
    assign mem_alu_out   = exmem_q.alu_out;
    assign mem_store_dat = exmem_q.store_dat;
    assign mem_pc        = exmem_q.pc;
    assign mem_wsel      = exmem_q.wsel;
    assign mem_halt      = halt_q;
    assign exc_pending   = pend_q;
    assign exc_pc        = epc_q;

endmodule

// File: tb/tb_exmem_latch.sv
// Randomised bench for exmem_latch against a behavioural model, plus directed
// scenarios with literal expectations; a TRAP_EN=0 copy shares the inputs.
module tb_exmem_latch;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    logic ex_valid, alu_zero, alu_neg, alu_ovf, ovf_chk;
    logic regwen, dren, dwen, halt, stall, flush, exc_ack;
    word_t alu_out, store_dat, ex_pc;
    regbits_t wsel;

    logic mem_valid, mem_zero, mem_neg, mem_regwen, mem_dren, mem_dwen, mem_halt;
    word_t mem_alu_out, mem_store_dat, mem_pc, exc_pc;
    regbits_t mem_wsel;
    logic exc_pending;

    logic n_valid, n_zero, n_neg, n_regwen, n_dren, n_dwen, n_halt, n_pend;
    word_t n_alu_out, n_store_dat, n_pc, n_epc;
    regbits_t n_wsel;

    int total = 0;
    int bad = 0;

    // Model state: what every output must hold.
    logic e_valid, e_zero, e_neg, e_regwen, e_dren, e_dwen, e_halt, e_pend;
    word_t e_alu, e_st, e_pc, e_epc;
    regbits_t e_wsel;

    always #5 CLK = ~CLK;

    exmem_latch #(.TRAP_EN(1'b1)) dut (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .ovf_chk(ovf_chk),
        .store_dat(store_dat), .wsel(wsel), .regwen(regwen), .dren(dren), .dwen(dwen),
        .halt(halt), .ex_pc(ex_pc), .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .mem_valid(mem_valid), .mem_zero(mem_zero), .mem_neg(mem_neg),
        .mem_regwen(mem_regwen), .mem_dren(mem_dren), .mem_dwen(mem_dwen),
        .mem_halt(mem_halt), .mem_alu_out(mem_alu_out), .mem_store_dat(mem_store_dat),
        .mem_pc(mem_pc), .mem_wsel(mem_wsel), .exc_pending(exc_pending), .exc_pc(exc_pc)
    );

    exmem_latch #(.TRAP_EN(1'b0)) dut_notrap (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .ovf_chk(ovf_chk),
        .store_dat(store_dat), .wsel(wsel), .regwen(regwen), .dren(dren), .dwen(dwen),
        .halt(halt), .ex_pc(ex_pc), .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .mem_valid(n_valid), .mem_zero(n_zero), .mem_neg(n_neg),
        .mem_regwen(n_regwen), .mem_dren(n_dren), .mem_dwen(n_dwen),
        .mem_halt(n_halt), .mem_alu_out(n_alu_out), .mem_store_dat(n_store_dat),
        .mem_pc(n_pc), .mem_wsel(n_wsel), .exc_pending(n_pend), .exc_pc(n_epc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        {e_valid, e_zero, e_neg, e_regwen, e_dren, e_dwen, e_halt, e_pend} = '0;
        e_alu = '0; e_st = '0; e_pc = '0; e_epc = '0; e_wsel = '0;
    endtask

    // Effect of one rising edge on the visible state, from the block's rules.
    task automatic model_edge();
        bit is_load, is_trap;
        is_load = !flush && !stall;
        is_trap = is_load && ex_valid && ovf_chk && alu_ovf;
        if (is_trap) begin
            if (!e_pend || exc_ack) e_epc = ex_pc;
            e_pend = 1'b1;
        end else if (exc_ack) begin
            e_pend = 1'b0;
        end
        if (flush) begin
            {e_valid, e_zero, e_neg, e_regwen, e_dren, e_dwen} = '0;
            e_alu = '0; e_st = '0; e_pc = '0; e_wsel = '0;
        end else if (is_load) begin
            e_valid  = ex_valid;
            e_zero   = alu_zero;
            e_neg    = alu_neg;
            e_alu    = alu_out;
            e_st     = store_dat;
            e_pc     = ex_pc;
            e_wsel   = wsel;
            e_regwen = ex_valid && regwen && wsel != 0 && !is_trap;
            e_dren   = ex_valid && dren && !is_trap;
            e_dwen   = ex_valid && dwen && !is_trap;
            if (ex_valid && halt) e_halt = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(mem_valid), 32'(e_valid));
        chk({tag, ".zero"}, 32'(mem_zero), 32'(e_zero));
        chk({tag, ".neg"}, 32'(mem_neg), 32'(e_neg));
        chk({tag, ".regwen"}, 32'(mem_regwen), 32'(e_regwen));
        chk({tag, ".dren"}, 32'(mem_dren), 32'(e_dren));
        chk({tag, ".dwen"}, 32'(mem_dwen), 32'(e_dwen));
        chk({tag, ".halt"}, 32'(mem_halt), 32'(e_halt));
        chk({tag, ".alu_out"}, mem_alu_out, e_alu);
        chk({tag, ".store_dat"}, mem_store_dat, e_st);
        chk({tag, ".pc"}, mem_pc, e_pc);
        chk({tag, ".wsel"}, 32'(mem_wsel), 32'(e_wsel));
        chk({tag, ".exc_pending"}, 32'(exc_pending), 32'(e_pend));
        chk({tag, ".exc_pc"}, exc_pc, e_epc);
        chk({tag, ".notrap_pending"}, 32'(n_pend), 32'd0);
    endtask

    task automatic clear_in();
        {ex_valid, alu_zero, alu_neg, alu_ovf, ovf_chk} = '0;
        {regwen, dren, dwen, halt, stall, flush, exc_ack} = '0;
        alu_out = '0; store_dat = '0; ex_pc = '0; wsel = '0;
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges must clear everything immediately.
    task automatic mid_reset(input string tag);
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".halt_lit"}, 32'(mem_halt), 32'd0);
        chk({tag, ".valid_lit"}, 32'(mem_valid), 32'd0);
        @(posedge CLK);
        #2;
        nRST = 1'b1;
    endtask

    task automatic random_inputs();
        ex_valid  = ($urandom_range(0, 7) != 0);
        alu_out   = $urandom;
        alu_zero  = 1'($urandom);
        alu_neg   = 1'($urandom);
        alu_ovf   = 1'($urandom);
        ovf_chk   = 1'($urandom);
        store_dat = $urandom;
        wsel      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        regwen    = 1'($urandom);
        dren      = 1'($urandom);
        dwen      = 1'($urandom);
        halt      = ($urandom_range(0, 99) == 0);
        ex_pc     = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
        stall     = ($urandom_range(0, 7) == 0);
        flush     = ($urandom_range(0, 9) == 0);
        exc_ack   = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        clear_in();
        nRST = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.exc_pc_lit", exc_pc, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Plain load.
        ex_valid = 1; alu_out = 32'h10; wsel = 5'd8; regwen = 1;
        step("load");
        chk("load.alu_lit", mem_alu_out, 32'h10);
        chk("load.wsel_lit", 32'(mem_wsel), 32'd8);
        chk("load.regwen_lit", 32'(mem_regwen), 32'd1);
        chk("load.valid_lit", 32'(mem_valid), 32'd1);

        // Trap, then a second trap that must not move exc_pc.
        ovf_chk = 1; alu_ovf = 1; ex_pc = 32'h40;
        step("trap1");
        chk("trap1.regwen_lit", 32'(mem_regwen), 32'd0);
        chk("trap1.pend_lit", 32'(exc_pending), 32'd1);
        chk("trap1.epc_lit", exc_pc, 32'h40);
        chk("trap1.valid_lit", 32'(mem_valid), 32'd1);
        chk("notrap.regwen_lit", 32'(n_regwen), 32'd1);
        ex_pc = 32'h44;
        step("trap2");
        chk("trap2.epc_lit", exc_pc, 32'h40);

        // Ack racing a new trap, then ack alone.
        ex_pc = 32'h80; exc_ack = 1;
        step("race");
        chk("race.pend_lit", 32'(exc_pending), 32'd1);
        chk("race.epc_lit", exc_pc, 32'h80);
        clear_in(); exc_ack = 1;
        step("ack");
        chk("ack.pend_lit", 32'(exc_pending), 32'd0);
        chk("ack.epc_lit", exc_pc, 32'h80);

        // Flush beats stall; then a 3-edge stall holds everything.
        clear_in(); ex_valid = 1; dwen = 1; alu_out = 32'h1234; wsel = 5'd3;
        step("pre_flush");
        stall = 1; flush = 1;
        step("flush");
        chk("flush.valid_lit", 32'(mem_valid), 32'd0);
        chk("flush.dwen_lit", 32'(mem_dwen), 32'd0);
        clear_in(); ex_valid = 1; dwen = 1; alu_out = 32'h1234; wsel = 5'd3;
        step("pre_stall");
        for (int i = 0; i < 3; i++) begin
            random_inputs(); stall = 1; flush = 0;
            step("stall");
        end
        chk("stall.alu_lit", mem_alu_out, 32'h1234);
        chk("stall.dwen_lit", 32'(mem_dwen), 32'd1);

        // Halt is sticky through flush; reset clears it.
        clear_in(); ex_valid = 1; halt = 1;
        step("halt");
        clear_in(); flush = 1;
        step("halt_flush");
        chk("halt_flush.lit", 32'(mem_halt), 32'd1);
        clear_in(); stall = 1; ex_valid = 1; ovf_chk = 1; alu_ovf = 1;
        mid_reset("rst_mid");
        clear_in(); ex_valid = 1; alu_out = 32'h55; wsel = 5'd2; regwen = 1;
        step("post_rst");
        chk("post_rst.alu_lit", mem_alu_out, 32'h55);

        // Register zero never gets a write enable.
        clear_in(); ex_valid = 1; regwen = 1; wsel = 5'd0;
        step("wsel0");
        chk("wsel0.regwen_lit", 32'(mem_regwen), 32'd0);

        // Unsigned overflow never traps.
        clear_in(); ex_valid = 1; alu_ovf = 1; ex_pc = 32'h100;
        step("unsigned");
        chk("unsigned.pend_lit", 32'(exc_pending), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            if ($urandom_range(0, 399) == 0) begin
                mid_reset("rand_rst");
                random_inputs();
            end
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
